pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the MIPS32 fetch stage: owns the PC register and picks the next fetch address.
//  Choices: sequential pc+4, branch/jump redirect, exception vector, or return from exception (ERET).
//  Sits between the branch-resolution/hazard logic and instruction memory.
//  Produces pc_o, a valid qualifier and a one-cycle flush request for the fetch/decode registers.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded by reset
//  EXC_VECTOR    32'h0000_0180  PC loaded on exception entry
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  stall_i      in   1   hold PC (hazard or memory wait)
//  br_taken_i   in   1   conditional branch resolved taken this cycle
//  br_target_i  in   32  branch target
//  jmp_valid_i  in   1   unconditional jump/JR this cycle
//  jmp_target_i in   32  jump target
//  exc_req_i    in   1   exception request; exc_pc_i is the faulting PC
//  exc_pc_i     in   32  PC saved into EPC on exception
//  eret_i       in   1   return from exception
//  pc_o         out  32  current fetch address
//  pc_valid_o   out  1   pc_o is a real fetch this cycle
//  flush_o      out  1   kill the younger in-flight instruction
//  epc_o        out  32  saved exception PC
// BEHAVIOUR
//  Reset: pc_o=RESET_VECTOR, epc_o=0, pc_valid_o=0, flush_o=0, pending cleared, state=BOOT.
//  FSM states: BOOT, RUN, PEND.
//   BOOT -> RUN after one cycle with pc_valid_o=0; pc is held at RESET_VECTOR.
//   RUN is normal; PEND means a redirect is captured and waiting to be applied.
//  Priority each cycle, highest first: exc_req_i > eret_i > jmp_valid_i > br_taken_i > stall_i > pc+4.
//  exc_req_i: pc<=EXC_VECTOR, epc<=exc_pc_i, flush_o=1 next cycle, pending cleared.
//   Overrides stall and any pending redirect.
//  eret_i: pc<=epc_o, flush_o=1, pending cleared; overrides stall.
//  Jump/branch when not stalled: pc<=target (no-delay-slot build), flush_o=1 for 1 cycle.
//  Jump/branch while stall_i=1: target captured in pend_q, state->PEND, PC held.
//   The target is applied on the first cycle with stall_i=0.
//   A later redirect arriving in PEND overwrites pend_q.
//  stall_i=1 alone: pc_o held; pc_valid_o stays 1 (same fetch reissued).
//  Targets: bits[1:0] forced to 0. pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
//  Latency: every redirect is visible on pc_o the cycle after its request.
//  Reset mid-operation: immediate return to the reset state; pending redirect discarded.
// CONFIGURATION
//  PC_SEQ_DELAY_SLOT_EN defined: MIPS branch delay slot.
//   A taken branch/jump first advances pc<=pc+4 (the slot), holding the target in pend_q (state PEND).
//   The next non-stalled cycle loads the target.
//   flush_o is never asserted for branches/jumps; it is still asserted for exc/eret.
//   Exception inside PEND discards the target.
//  Macro undefined: redirect is immediate with a flush_o pulse (as above).
// STRUCTURE
//  Shared package mips_pkg holds:
//   - typedef logic [31:0] addr_t
//   - localparam PC_INC=4
//   - the FSM state enum pcs_state_t {BOOT,RUN,PEND}
//  One sub-module: pc_next_mux, a combinational priority select of the next-PC source.
//  The FSM, pend_q, epc and the PC register stay in pc_sequencer.
// TESTING
//  1) Reset, release, 3 free cycles -> pc_o 0,0,4,8; pc_valid_o 0,1,1,1.
//  2) Branch at pc=0x10, br_target_i=0x40 -> pc_o=0x40 next cycle, flush_o=1 for one cycle.
//     With DELAY_SLOT_EN: pc_o 0x14 then 0x40, flush_o stays 0.
//  3) jmp_valid_i with stall_i=1 for 2 cycles, target 0x100 -> pc held.
//     pc_o=0x100 the cycle after stall_i falls.
//  4) exc_req_i with br_taken_i same cycle, exc_pc_i=0x20 -> pc_o=0x180, epc_o=0x20.
//     Then eret_i -> pc_o=0x20, flush_o=1.
//  5) pc at 0xFFFF_FFFC, no events -> pc_o=0x0000_0000.
//  6) Assert reset while in PEND -> pc_o=RESET_VECTOR; pending target never appears on pc_o.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the MIPS32 fetch-stage PC sequencer
package mips_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } pcs_state_t;

  typedef enum logic [3:0] {
    SRC_HOLD,
    SRC_SEQ,
    SRC_EXC,
    SRC_ERET,
    SRC_REDIR,
    SRC_CAPTURE,
    SRC_SLOT,
    SRC_PEND_SLOT,
    SRC_PEND
  } pc_src_t;

  function automatic addr_t align_word(addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational priority select of the next fetch PC source
module pc_next_mux
  import mips_pkg::*;
#(
  parameter addr_t EXC_VECTOR = 32'h0000_0180
) (
  input  logic    run,
  input  logic    exc_req,
  input  logic    eret,
  input  logic    jmp_valid,
  input  logic    br_taken,
  input  logic    stall,
  input  logic    pend_active,
  input  logic    pend_slot_due,
  input  logic    slot_en,
  input  addr_t   pc,
  input  addr_t   epc,
  input  addr_t   jmp_target,
  input  addr_t   br_target,
  input  addr_t   pend_target,
  output pc_src_t src,
  output addr_t   next_pc,
  output addr_t   redir_target
);

  always_comb begin
    redir_target = align_word(jmp_valid ? jmp_target : br_target);
    src          = SRC_SEQ;
    next_pc      = pc + PC_INC;
    if (!run) begin
      src     = SRC_HOLD;
      next_pc = pc;
    end else if (exc_req) begin
      src     = SRC_EXC;
      next_pc = EXC_VECTOR;
    end else if (eret) begin
      src     = SRC_ERET;
      next_pc = epc;
    end else if (jmp_valid || br_taken) begin
      if (stall) begin
        src     = SRC_CAPTURE;
        next_pc = pc;
      end else if (slot_en) begin
        // delay slot is fetched first; the target waits in the pending register
        src     = SRC_SLOT;
        next_pc = pc + PC_INC;
      end else begin
        src     = SRC_REDIR;
        next_pc = redir_target;
      end
    end else if (stall) begin
      src     = SRC_HOLD;
      next_pc = pc;
    end else if (pend_active) begin
      if (pend_slot_due) begin
        src     = SRC_PEND_SLOT;
        next_pc = pc + PC_INC;
      end else begin
        src     = SRC_PEND;
        next_pc = pend_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS32 next-PC controller; PC_SEQ_DELAY_SLOT_EN enables the branch delay slot
module pc_sequencer
  import mips_pkg::*;
#(
  parameter addr_t RESET_VECTOR = 32'h0000_0000,
  parameter addr_t EXC_VECTOR   = 32'h0000_0180
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall_i,
  input  logic  br_taken_i,
  input  addr_t br_target_i,
  input  logic  jmp_valid_i,
  input  addr_t jmp_target_i,
  input  logic  exc_req_i,
  input  addr_t exc_pc_i,
  input  logic  eret_i,
  output addr_t pc_o,
  output logic  pc_valid_o,
  output logic  flush_o,
  output addr_t epc_o
);

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam logic SLOT_EN = 1'b1;
`else
  localparam logic SLOT_EN = 1'b0;
`endif

  pcs_state_t state_q, state_d;
  addr_t      pc_q, epc_q, epc_d, pend_q, pend_d;
  logic       slot_done_q, slot_done_d;
  logic       flush_q, flush_d;
  pc_src_t    src;
  addr_t      next_pc, redir_target;

  pc_next_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_mux (
    .run          (state_q != BOOT),
    .exc_req      (exc_req_i),
    .eret         (eret_i),
    .jmp_valid    (jmp_valid_i),
    .br_taken     (br_taken_i),
    .stall        (stall_i),
    .pend_active  (state_q == PEND),
    .pend_slot_due(SLOT_EN && !slot_done_q),
    .slot_en      (SLOT_EN),
    .pc           (pc_q),
    .epc          (epc_q),
    .jmp_target   (jmp_target_i),
    .br_target    (br_target_i),
    .pend_target  (pend_q),
    .src          (src),
    .next_pc      (next_pc),
    .redir_target (redir_target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      pend_q      <= '0;
      slot_done_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= next_pc;
      epc_q       <= epc_d;
      pend_q      <= pend_d;
      slot_done_q <= slot_done_d;
      flush_q     <= flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    pend_d      = pend_q;
    slot_done_d = slot_done_q;
    flush_d     = 1'b0;
    unique case (src)
      SRC_HOLD: begin
        if (state_q == BOOT) state_d = RUN;
      end
      SRC_EXC: begin
        epc_d   = exc_pc_i;
        flush_d = 1'b1;
        state_d = RUN;
      end
      SRC_ERET: begin
        flush_d = 1'b1;
        state_d = RUN;
      end
      SRC_REDIR: begin
        flush_d = 1'b1;
        state_d = RUN;
      end
      SRC_CAPTURE: begin
        // a newer redirect replaces any older one and owes its own delay slot
        pend_d      = redir_target;
        slot_done_d = 1'b0;
        state_d     = PEND;
      end
      SRC_SLOT: begin
        pend_d      = redir_target;
        slot_done_d = 1'b1;
        state_d     = PEND;
      end
      SRC_PEND_SLOT: begin
        slot_done_d = 1'b1;
      end
      SRC_PEND: begin
        flush_d = !SLOT_EN;
        state_d = RUN;
      end
      default: begin
      end
    endcase
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q != BOOT);
  assign flush_o    = flush_q;
  assign epc_o      = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, br_taken_i, jmp_valid_i, exc_req_i, eret_i;
  logic [31:0] br_target_i, jmp_target_i, exc_pc_i;
  logic [31:0] pc_o, epc_o;
  logic        pc_valid_o, flush_o;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .jmp_valid_i (jmp_valid_i),
    .jmp_target_i(jmp_target_i),
    .exc_req_i   (exc_req_i),
    .exc_pc_i    (exc_pc_i),
    .eret_i      (eret_i),
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .flush_o     (flush_o),
    .epc_o       (epc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pc(input string tag, input logic [31:0] pc, input logic valid, input logic flush);
    check({tag, " pc"}, pc_o, pc);
    check({tag, " valid"}, {31'd0, pc_valid_o}, {31'd0, valid});
    check({tag, " flush"}, {31'd0, flush_o}, {31'd0, flush});
  endtask

  initial begin
    reset = 1'b1;
    stall_i = 0; br_taken_i = 0; jmp_valid_i = 0; exc_req_i = 0; eret_i = 0;
    br_target_i = 0; jmp_target_i = 0; exc_pc_i = 0;
    tick(); tick();
    check_pc("reset", 32'h0, 1'b0, 1'b0);
    check("reset epc", epc_o, 32'h0);

    // 1) boot then sequential fetch
    reset = 1'b0;
    check_pc("boot", 32'h0, 1'b0, 1'b0);
    tick(); check_pc("run0", 32'h0, 1'b1, 1'b0);
    tick(); check_pc("run4", 32'h4, 1'b1, 1'b0);
    tick(); check_pc("run8", 32'h8, 1'b1, 1'b0);
    tick(); tick(); check_pc("at10", 32'h10, 1'b1, 1'b0);

    // 2) taken branch at 0x10
    br_taken_i = 1; br_target_i = 32'h40;
    tick(); br_taken_i = 0;
`ifdef PC_SEQ_DELAY_SLOT_EN
    check_pc("br slot", 32'h14, 1'b1, 1'b0);
    tick(); check_pc("br target", 32'h40, 1'b1, 1'b0);
    tick();
`else
    check_pc("br target", 32'h40, 1'b1, 1'b1);
    tick();
`endif
    check_pc("br after", 32'h44, 1'b1, 1'b0);

    // 3) jump under a two-cycle stall
    stall_i = 1; jmp_valid_i = 1; jmp_target_i = 32'h100;
    tick(); check_pc("stall1", 32'h44, 1'b1, 1'b0);
    tick(); check_pc("stall2", 32'h44, 1'b1, 1'b0);
    stall_i = 0; jmp_valid_i = 0;
    tick();
`ifdef PC_SEQ_DELAY_SLOT_EN
    check_pc("jmp slot", 32'h48, 1'b1, 1'b0);
    tick(); check_pc("jmp target", 32'h100, 1'b1, 1'b0);
`else
    check_pc("jmp target", 32'h100, 1'b1, 1'b1);
`endif
    tick(); check_pc("jmp after", 32'h104, 1'b1, 1'b0);

    // 4) exception beats a same-cycle branch, then ERET
    exc_req_i = 1; exc_pc_i = 32'h20; br_taken_i = 1; br_target_i = 32'h300;
    tick(); exc_req_i = 0; br_taken_i = 0;
    check_pc("exc", 32'h180, 1'b1, 1'b1);
    check("exc epc", epc_o, 32'h20);
    tick(); check_pc("exc next", 32'h184, 1'b1, 1'b0);
    eret_i = 1; stall_i = 1;
    tick(); eret_i = 0; stall_i = 0;
    check_pc("eret", 32'h20, 1'b1, 1'b1);
    tick(); check_pc("eret next", 32'h24, 1'b1, 1'b0);

    // unaligned target has its low bits cleared
    jmp_valid_i = 1; jmp_target_i = 32'h203;
    tick(); jmp_valid_i = 0;
`ifdef PC_SEQ_DELAY_SLOT_EN
    check_pc("align slot", 32'h28, 1'b1, 1'b0);
    tick(); check_pc("align", 32'h200, 1'b1, 1'b0);
`else
    check_pc("align", 32'h200, 1'b1, 1'b1);
`endif

    // 5) wrap from the top of the address space
    jmp_valid_i = 1; jmp_target_i = 32'hFFFF_FFFC;
    tick(); jmp_valid_i = 0;
`ifdef PC_SEQ_DELAY_SLOT_EN
    check_pc("wrap slot", 32'h204, 1'b1, 1'b0);
    tick();
`endif
    check("wrap top", pc_o, 32'hFFFF_FFFC);
    tick(); check_pc("wrap", 32'h0, 1'b1, 1'b0);

    // 6) reset while a redirect is pending
    tick(); tick(); check("pre pend", pc_o, 32'h8);
    stall_i = 1; jmp_valid_i = 1; jmp_target_i = 32'h500;
    tick(); check_pc("pend held", 32'h8, 1'b1, 1'b0);
    reset = 1; #1;
    check_pc("async reset", 32'h0, 1'b0, 1'b0);
    tick();
    reset = 0; stall_i = 0; jmp_valid_i = 0;
    check_pc("reboot", 32'h0, 1'b0, 1'b0);
    tick(); check_pc("reboot run0", 32'h0, 1'b1, 1'b0);
    tick(); check_pc("reboot run4", 32'h4, 1'b1, 1'b0);
    tick(); check_pc("reboot run8", 32'h8, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
